// File: rtl/ysyx_22041071_axi_rd_arb_pkg.sv
// Shared types and constants for the IF/LSU AXI read arbiter.
// Widths mirror the core-wide address/data/response bus widths.
package ysyx_22041071_axi_rd_arb_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int RESP_W = 2;

    // Instruction fetches are always 4-byte reads.
    localparam logic [2:0] IF_SIZE = 3'b010;
    localparam logic [7:0] AR_LEN  = 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_LSU = 1'b1
    } arb_gnt_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        size;
    } ar_req_t;

    function automatic arb_gnt_e other_gnt(input arb_gnt_e g);
        return (g == GNT_IF) ? GNT_LSU : GNT_IF;
    endfunction

endpackage

// File: rtl/ysyx_22041071_axi_rd_arb_if.sv
// Bundle of the requester-side and master-side read channels of the arbiter.
// master: the arbiter's view; slave: the surrounding IF/LSU stages and AXI slave.
interface ysyx_22041071_axi_rd_arb_if #(
    parameter int ADDR_W = ysyx_22041071_axi_rd_arb_pkg::ADDR_W,
    parameter int DATA_W = ysyx_22041071_axi_rd_arb_pkg::DATA_W,
    parameter int RESP_W = ysyx_22041071_axi_rd_arb_pkg::RESP_W
);
    logic              if_ar_valid;
    logic              if_ar_ready;
    logic [ADDR_W-1:0] if_ar_addr;
    logic              if_r_valid;
    logic              if_r_ready;
    logic [DATA_W-1:0] if_r_data;
    logic [RESP_W-1:0] if_r_resp;
    logic [ADDR_W-1:0] if_r_addr;
    logic              if_flush;

    logic              lsu_ar_valid;
    logic              lsu_ar_ready;
    logic [ADDR_W-1:0] lsu_ar_addr;
    logic [2:0]        lsu_ar_size;
    logic              lsu_r_valid;
    logic              lsu_r_ready;
    logic [DATA_W-1:0] lsu_r_data;
    logic [RESP_W-1:0] lsu_r_resp;

    logic              m_ar_valid;
    logic              m_ar_ready;
    logic [ADDR_W-1:0] m_ar_addr;
    logic [2:0]        m_ar_size;
    logic [7:0]        m_ar_len;
    logic              m_r_valid;
    logic              m_r_ready;
    logic              m_r_last;
    logic [DATA_W-1:0] m_r_data;
    logic [RESP_W-1:0] m_r_resp;

    modport master (
        input  if_ar_valid, if_ar_addr, if_r_ready, if_flush,
        input  lsu_ar_valid, lsu_ar_addr, lsu_ar_size, lsu_r_ready,
        input  m_ar_ready, m_r_valid, m_r_last, m_r_data, m_r_resp,
        output if_ar_ready, if_r_valid, if_r_data, if_r_resp, if_r_addr,
        output lsu_ar_ready, lsu_r_valid, lsu_r_data, lsu_r_resp,
        output m_ar_valid, m_ar_addr, m_ar_size, m_ar_len, m_r_ready
    );

    modport slave (
        output if_ar_valid, if_ar_addr, if_r_ready, if_flush,
        output lsu_ar_valid, lsu_ar_addr, lsu_ar_size, lsu_r_ready,
        output m_ar_ready, m_r_valid, m_r_last, m_r_data, m_r_resp,
        input  if_ar_ready, if_r_valid, if_r_data, if_r_resp, if_r_addr,
        input  lsu_ar_ready, lsu_r_valid, lsu_r_data, lsu_r_resp,
        input  m_ar_valid, m_ar_addr, m_ar_size, m_ar_len, m_r_ready
    );

endinterface

// File: rtl/ysyx_22041071_axi_rd_arb_pick.sv
// Two-way grant picker: LSU-over-IF fixed priority by default, or round-robin
// on simultaneous requests when YSYX_22041071_ARB_RR_EN is defined.
module ysyx_22041071_arb2_pick
    import ysyx_22041071_axi_rd_arb_pkg::*;
(
    input  logic     req_if,
    input  logic     req_lsu,
`ifdef YSYX_22041071_ARB_RR_EN
    input  arb_gnt_e favour,
`endif
    output arb_gnt_e gnt
);

    always_comb begin
        gnt = GNT_IF;
        if (req_if && req_lsu) begin
`ifdef YSYX_22041071_ARB_RR_EN
            gnt = favour;
`else
            gnt = GNT_LSU;
`endif
        end else if (req_lsu) begin
            gnt = GNT_LSU;
        end
    end

endmodule

// File: rtl/ysyx_22041071_axi_rd_arb.sv
// Serialises single-beat IF/LSU reads onto one AXI read master and routes R beats
// back to the owner; YSYX_22041071_ARB_RR_EN selects round-robin arbitration.
module ysyx_22041071_axi_rd_arb
    import ysyx_22041071_axi_rd_arb_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    ysyx_22041071_axi_rd_arb_if.master      bus,
    output logic                            busy
);

    arb_state_e state_reg;
    arb_gnt_e   gnt_reg;
    arb_gnt_e   gnt_next;
    ar_req_t    req_reg;
    logic       m_ar_valid_reg;
    logic       busy_reg;
    logic       drop_reg;

    logic       in_ar;
    logic       in_r;
    logic       if_owned;
    logic       lsu_owned;
    logic       drop_now;
    logic       beat_last;

`ifdef YSYX_22041071_ARB_RR_EN
    arb_gnt_e   ptr_reg;

    ysyx_22041071_arb2_pick u_pick (
        .req_if  (bus.if_ar_valid),
        .req_lsu (bus.lsu_ar_valid),
        .favour  (ptr_reg),
        .gnt     (gnt_next)
    );
`else
    ysyx_22041071_arb2_pick u_pick (
        .req_if  (bus.if_ar_valid),
        .req_lsu (bus.lsu_ar_valid),
        .gnt     (gnt_next)
    );
`endif

    assign in_ar     = (state_reg == ST_AR);
    assign in_r      = (state_reg == ST_R);
    assign if_owned  = (gnt_reg == GNT_IF);
    assign lsu_owned = (gnt_reg == GNT_LSU);

    // A flush in the beat's own cycle must already suppress it, so OR it in here.
    assign drop_now  = drop_reg | (bus.if_flush & if_owned);

    assign bus.if_ar_ready  = in_ar & if_owned  & bus.m_ar_ready;
    assign bus.lsu_ar_ready = in_ar & lsu_owned & bus.m_ar_ready;

    assign bus.if_r_valid   = in_r & if_owned  & bus.m_r_valid & ~drop_now;
    assign bus.lsu_r_valid  = in_r & lsu_owned & bus.m_r_valid;
    assign bus.m_r_ready    = in_r & (if_owned ? (drop_now | bus.if_r_ready)
                                               : bus.lsu_r_ready);

    assign bus.if_r_data    = bus.m_r_data;
    assign bus.if_r_resp    = bus.m_r_resp;
    assign bus.if_r_addr    = req_reg.addr;
    assign bus.lsu_r_data   = bus.m_r_data;
    assign bus.lsu_r_resp   = bus.m_r_resp;

    assign bus.m_ar_valid   = m_ar_valid_reg;
    assign bus.m_ar_addr    = req_reg.addr;
    assign bus.m_ar_size    = req_reg.size;
    assign bus.m_ar_len     = AR_LEN;
    assign busy             = busy_reg;

    assign beat_last        = bus.m_r_valid & bus.m_r_ready & bus.m_r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            gnt_reg        <= GNT_IF;
            req_reg        <= '0;
            m_ar_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            drop_reg       <= 1'b0;
`ifdef YSYX_22041071_ARB_RR_EN
            ptr_reg        <= GNT_LSU;
`endif
        end else begin
            // AR stays up after a flush; only the returning beat is discarded.
            if (bus.if_flush && if_owned && state_reg != ST_IDLE) begin
                drop_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (bus.if_ar_valid || bus.lsu_ar_valid) begin
                        state_reg      <= ST_AR;
                        gnt_reg        <= gnt_next;
                        m_ar_valid_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                        drop_reg       <= 1'b0;
                        if (gnt_next == GNT_LSU) begin
                            req_reg.addr <= bus.lsu_ar_addr;
                            req_reg.size <= bus.lsu_ar_size;
                        end else begin
                            req_reg.addr <= bus.if_ar_addr;
                            req_reg.size <= IF_SIZE;
                        end
                    end
                end

                ST_AR: begin
                    if (bus.m_ar_ready) begin
                        state_reg      <= ST_R;
                        m_ar_valid_reg <= 1'b0;
                    end
                end

                ST_R: begin
                    if (beat_last) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        drop_reg  <= 1'b0;
`ifdef YSYX_22041071_ARB_RR_EN
                        ptr_reg   <= other_gnt(gnt_reg);
`endif
                    end
                end

                default: begin
                    state_reg      <= ST_IDLE;
                    m_ar_valid_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                    drop_reg       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
// Bench for the IF/LSU read arbiter: transaction-level model plus directed scenarios
// and randomized traffic (requesters, flushes, slave latency, multi-beat, resets).
`timescale 1ns/1ps
module tb_ysyx_22041071_axi_rd_arb;
    import ysyx_22041071_axi_rd_arb_pkg::*;

`ifdef YSYX_22041071_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    ysyx_22041071_axi_rd_arb_if bus ();

    ysyx_22041071_axi_rd_arb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Transaction model: one read in flight, owner 1 = LSU, 0 = IF.
    bit          m_active, m_accepted, m_stale, m_owner, m_last_lsu;
    logic [63:0] m_addr;
    logic [2:0]  m_size;
    int          n_done;

    // Requesters
    bit          if_pend, lsu_pend;
    logic [63:0] if_addr_q, lsu_addr_q;
    logic [2:0]  lsu_size_q;

    // Slave
    bit          s_busy;
    int          s_wait, s_beats;
    logic [63:0] s_data;
    logic [1:0]  s_resp;

    // Knobs
    bit          rnd, gen_req, f_en, flush_now, reset_drv, rdy_off;
    int          fix_lat;
    logic [63:0] f_data;
    logic [1:0]  f_resp;

    // Observations of DUT outputs for directed literal checks
    bit          obs_if_rv, obs_lsu_rv, obs_mrr_beat, prev_mav;
    logic [63:0] obs_if_data, obs_if_addr;
    logic [1:0]  obs_if_resp, obs_lsu_resp;
    logic [2:0]  obs_ar_size;
    int          obs_lsu_last_cyc;
    logic [63:0] ar_addr_log[$];
    int          ar_cyc_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic new_beat();
        s_data = f_en ? f_data : {$urandom, $urandom};
        s_resp = f_en ? f_resp : 2'($urandom_range(0, 3));
    endtask

    task automatic tick();
        bit dphase, stale, e_arv, e_ifar, e_lsar, e_ifrv, e_lsrv, e_mrr;
        bit hs_ar, hs_beat, hs_last;
        @(negedge clk);
        cyc++;
        reset            = reset_drv;
        bus.if_ar_valid  = if_pend;
        bus.if_ar_addr   = if_addr_q;
        bus.lsu_ar_valid = lsu_pend;
        bus.lsu_ar_addr  = lsu_addr_q;
        bus.lsu_ar_size  = lsu_size_q;
        bus.m_ar_ready   = !reset_drv && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
        bus.m_r_valid    = !reset_drv && s_busy && (s_wait == 0);
        bus.m_r_last     = (s_beats == 1);
        bus.m_r_data     = s_data;
        bus.m_r_resp     = s_resp;
        bus.if_r_ready   = !rdy_off && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        bus.lsu_r_ready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.if_flush     = flush_now || (rnd && $urandom_range(0, 15) == 0);
        flush_now        = 1'b0;
        #1;
        dphase = m_active && m_accepted;
        stale  = m_stale || (bus.if_flush && !m_owner);
        e_arv  = m_active && !m_accepted;
        e_ifar = e_arv && !m_owner && bus.m_ar_ready;
        e_lsar = e_arv && m_owner && bus.m_ar_ready;
        e_ifrv = dphase && !m_owner && bus.m_r_valid && !stale;
        e_lsrv = dphase && m_owner && bus.m_r_valid;
        e_mrr  = dphase && (m_owner ? bus.lsu_r_ready : (stale || bus.if_r_ready));
        if (!reset_drv) begin
            chk("busy", busy, m_active);
            chk("m_ar_valid", bus.m_ar_valid, e_arv);
            chk("m_ar_len", bus.m_ar_len, 0);
            chk("if_ar_ready", bus.if_ar_ready, e_ifar);
            chk("lsu_ar_ready", bus.lsu_ar_ready, e_lsar);
            chk("if_r_valid", bus.if_r_valid, e_ifrv);
            chk("lsu_r_valid", bus.lsu_r_valid, e_lsrv);
            chk("m_r_ready", bus.m_r_ready, e_mrr);
            if (e_arv) begin
                chk("m_ar_addr", bus.m_ar_addr, m_addr);
                chk("m_ar_size", bus.m_ar_size, m_size);
            end
            if (e_ifrv) begin
                chk("if_r_data", bus.if_r_data, s_data);
                chk("if_r_resp", bus.if_r_resp, s_resp);
                chk("if_r_addr", bus.if_r_addr, m_addr);
            end
            if (e_lsrv) begin
                chk("lsu_r_data", bus.lsu_r_data, s_data);
                chk("lsu_r_resp", bus.lsu_r_resp, s_resp);
            end
            if (bus.if_r_valid) begin
                obs_if_rv = 1'b1; obs_if_data = bus.if_r_data;
                obs_if_addr = bus.if_r_addr; obs_if_resp = bus.if_r_resp;
            end
            if (bus.lsu_r_valid) begin
                obs_lsu_rv = 1'b1; obs_lsu_resp = bus.lsu_r_resp;
                if (bus.lsu_r_ready && bus.m_r_last) obs_lsu_last_cyc = cyc;
            end
            if (bus.m_ar_valid) obs_ar_size = bus.m_ar_size;
            if (bus.m_ar_valid && !prev_mav) begin
                ar_addr_log.push_back(bus.m_ar_addr);
                ar_cyc_log.push_back(cyc);
            end
            if (bus.m_r_valid && bus.m_r_last && bus.m_r_ready) obs_mrr_beat = 1'b1;
            prev_mav = bus.m_ar_valid;
        end
        hs_ar   = e_arv && bus.m_ar_ready;
        hs_beat = dphase && bus.m_r_valid && e_mrr;
        hs_last = hs_beat && bus.m_r_last;
        if (reset_drv) begin
            m_active = 0; m_accepted = 0; m_stale = 0; m_last_lsu = 0;
            s_busy = 0; s_wait = 0; s_beats = 0; prev_mav = 0;
        end else begin
            if (!m_active) begin
                if (if_pend || lsu_pend) begin
                    if (if_pend && lsu_pend) m_owner = RR ? !m_last_lsu : 1'b1;
                    else                     m_owner = lsu_pend;
                    m_addr = m_owner ? lsu_addr_q : if_addr_q;
                    m_size = m_owner ? lsu_size_q : IF_SIZE;
                    m_active = 1; m_accepted = 0; m_stale = 0;
                end
            end else begin
                if (bus.if_flush && !m_owner) m_stale = 1;
                if (hs_ar) m_accepted = 1;
                if (hs_last) begin
                    $display("read %s addr=%h data=%h resp=%0d%s", m_owner ? "LSU" : "IF ",
                             m_addr, s_data, s_resp, stale ? " dropped" : "");
                    m_active = 0; m_last_lsu = m_owner; n_done++;
                end
            end
            if (e_ifar) if_pend = 0;
            if (e_lsar) lsu_pend = 0;
            if (s_busy && hs_beat) begin
                s_beats--;
                if (s_beats == 0) s_busy = 0;
                else new_beat();
            end else if (s_busy && s_wait > 0) begin
                s_wait--;
            end
            if (hs_ar) begin
                s_busy  = 1;
                s_wait  = rnd ? $urandom_range(0, 3) : fix_lat;
                s_beats = rnd ? $urandom_range(1, 2) : 1;
                new_beat();
            end
        end
        if (gen_req) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_addr_q = {$urandom, $urandom} & ~64'h3;
            end
            if (!lsu_pend && $urandom_range(0, 2) == 0) begin
                lsu_pend = 1; lsu_addr_q = {$urandom, $urandom};
                lsu_size_q = 3'($urandom_range(0, 3));
            end
        end
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int n = 0;
        while ((m_active || if_pend || lsu_pend) && n < bound) begin
            tick(); n++;
        end
        chk(nm, (m_active || if_pend || lsu_pend), 0);
    endtask

    task automatic wait_accepted(input string nm, input int bound);
        int n = 0;
        while (!(m_active && m_accepted) && n < bound) begin
            tick(); n++;
        end
        chk(nm, (m_active && m_accepted), 1);
    endtask

    task automatic clear_obs();
        obs_if_rv = 0; obs_lsu_rv = 0; obs_mrr_beat = 0;
        obs_lsu_last_cyc = -1;
        ar_addr_log.delete(); ar_cyc_log.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        bus.if_ar_valid = 0; bus.lsu_ar_valid = 0; bus.m_ar_ready = 0; bus.m_r_valid = 0;
        bus.if_flush = 0; bus.if_r_ready = 0; bus.lsu_r_ready = 0;
        if_addr_q = 0; lsu_addr_q = 0; lsu_size_q = 0; s_data = 0; s_resp = 0;
        fix_lat = 0; f_data = 0; f_resp = 0;
        reset_drv = 1;
        tick(); tick();
        reset_drv = 0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_m_ar_valid", bus.m_ar_valid, 0);
        chk("rst_m_ar_addr", bus.m_ar_addr, 0);
        chk("rst_m_ar_size", bus.m_ar_size, 0);
        chk("rst_m_r_ready", bus.m_r_ready, 0);

        // IF-only read, slave answers two cycles after AR acceptance
        clear_obs();
        fix_lat = 2; f_en = 1; f_data = 64'h1122334455667788; f_resp = 2'b00;
        if_pend = 1; if_addr_q = 64'h0000_0000_8000_0004;
        c0 = cyc + 1;
        wait_idle("t1_timeout", 20);
        chk("t1_if_rv_seen", obs_if_rv, 1);
        chk("t1_if_r_data", obs_if_data, 64'h1122334455667788);
        chk("t1_if_r_addr", obs_if_addr, 64'h0000_0000_8000_0004);
        chk("t1_if_r_resp", obs_if_resp, 2'b00);
        chk("t1_m_ar_size", obs_ar_size, 3'b010);
        chk("t1_lsu_rv_seen", obs_lsu_rv, 0);
        chk("t1_ar_count", ar_cyc_log.size(), 1);
        if (ar_cyc_log.size() >= 1) chk("t1_ar_latency", ar_cyc_log[0], c0 + 1);

        // Simultaneous IF + LSU: LSU first in both builds (IF was served last)
        clear_obs();
        f_en = 0; fix_lat = 0;
        if_pend = 1; if_addr_q = 64'h1000;
        lsu_pend = 1; lsu_addr_q = 64'h2000; lsu_size_q = 3'b011;
        wait_idle("t2_timeout", 40);
        chk("t2_ar_count", ar_addr_log.size(), 2);
        if (ar_addr_log.size() >= 2) begin
            chk("t2_first_lsu", ar_addr_log[0], 64'h2000);
            chk("t2_second_if", ar_addr_log[1], 64'h1000);
            chk("t2_idle_gap", ar_cyc_log[1] - obs_lsu_last_cyc, 2);
        end

        // LSU served last, then simultaneous requests
        lsu_pend = 1; lsu_addr_q = 64'h3000; lsu_size_q = 3'b001;
        wait_idle("t3a_timeout", 20);
        clear_obs();
        if_pend = 1; if_addr_q = 64'h4000;
        lsu_pend = 1; lsu_addr_q = 64'h5000; lsu_size_q = 3'b010;
        wait_idle("t3_timeout", 40);
        chk("t3_ar_count", ar_addr_log.size(), 2);
        if (ar_addr_log.size() >= 1)
            chk("t3_winner", ar_addr_log[0], RR ? 64'h4000 : 64'h5000);

        // Flush in R before the beat: beat swallowed even with if_r_ready low
        clear_obs();
        fix_lat = 3; rdy_off = 1;
        if_pend = 1; if_addr_q = 64'h6000;
        wait_accepted("t4_accept_timeout", 10);
        flush_now = 1;
        wait_idle("t4_timeout", 20);
        chk("t4_if_rv_seen", obs_if_rv, 0);
        chk("t4_m_r_ready_beat", obs_mrr_beat, 1);
        tick();
        chk("t4_busy_after", busy, 0);
        rdy_off = 0;

        // LSU read with SLVERR
        clear_obs();
        fix_lat = 1; f_en = 1; f_data = 64'hdead_beef_0bad_f00d; f_resp = 2'b10;
        lsu_pend = 1; lsu_addr_q = 64'h7000; lsu_size_q = 3'b011;
        wait_idle("t5_timeout", 20);
        chk("t5_lsu_rv_seen", obs_lsu_rv, 1);
        chk("t5_lsu_r_resp", obs_lsu_resp, 2'b10);
        tick();
        chk("t5_busy_after", busy, 0);
        f_en = 0;

        // Reset while in R
        fix_lat = 5;
        lsu_pend = 1; lsu_addr_q = 64'h8000; lsu_size_q = 3'b000;
        wait_accepted("t6_accept_timeout", 10);
        tick();
        chk("t6_busy_in_r", busy, 1);
        reset_drv = 1;
        tick();
        reset_drv = 0;
        tick();
        chk("t6_m_ar_valid", bus.m_ar_valid, 0);
        chk("t6_m_r_ready", bus.m_r_ready, 0);
        chk("t6_busy", busy, 0);

        // Randomized traffic with occasional resets
        n_done = 0;
        rnd = 1; gen_req = 1;
        for (int i = 0; i < 4000; i++) begin
            reset_drv = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset_drv = 0; gen_req = 0;
        wait_idle("drain_timeout", 200);
        chk("random_progress", (n_done > 200), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
